// File: rtl/kgp_pkg.sv
// KGP_RISC control constants: opcodes, FSM states, mux codes.
// Shared by the control sequencer and its watchdog.
package kgp_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERROR
  } state_t;

  localparam logic [2:0] OP_RALU   = 3'b000;
  localparam logic [2:0] OP_IALU   = 3'b001;
  localparam logic [2:0] OP_LOAD   = 3'b010;
  localparam logic [2:0] OP_STORE  = 3'b011;
  localparam logic [2:0] OP_BRANCH = 3'b100;
  localparam logic [2:0] OP_SYS    = 3'b111;

  localparam logic [3:0] FUNC_HALT = 4'b1111;

  localparam logic [1:0] PC_INC   = 2'b00;
  localparam logic [1:0] PC_LABEL = 2'b01;
  localparam logic [1:0] PC_REG   = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  localparam logic [1:0] BC_ALWAYS = 2'b00;
  localparam logic [1:0] BC_Z      = 2'b01;
  localparam logic [1:0] BC_C      = 2'b10;
  localparam logic [1:0] BC_S      = 2'b11;

  function automatic logic branch_taken(
    input logic [1:0] cond,
    input logic       z,
    input logic       c,
    input logic       s
  );
    logic t;
    t = 1'b0;
    case (cond)
      BC_ALWAYS: t = 1'b1;
      BC_Z:      t = z;
      BC_C:      t = c;
      BC_S:      t = s;
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/kgp_mem_watchdog.sv
// Counts consecutive wait cycles of a memory request.
// Saturates at MEM_TIMEOUT-1 and flags a timeout there.
module kgp_mem_watchdog
  import kgp_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && count != LIMIT) begin
      count <= count + CNT_W'(1);
    end
  end

  assign timeout = inc && (count == LIMIT);

endmodule

// File: rtl/kgp_control_fsm.sv
// Multi-cycle control sequencer for the KGP_RISC core.
// Moore outputs, except memory-accept strobes gated by mem_ready.
module kgp_control_fsm
  import kgp_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic [3:0] func,
  input  logic       flag_z,
  input  logic       flag_c,
  input  logic       flag_s,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_src_imm,
  output logic       retire,
  output logic       halted,
  output logic       error
);

  state_t state, state_nx;
  logic   mem_wait, timeout;
  logic   is_halt, is_legal, taken;

  assign mem_wait = (state == S_FETCH || state == S_MEM) && !mem_ready;
  assign is_halt  = (opcode == OP_SYS) && (func == FUNC_HALT);
  assign is_legal = opcode <= OP_BRANCH;
  assign taken    = branch_taken(func[1:0], flag_z, flag_c, flag_s);

  kgp_mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clear  (!mem_wait),
    .inc    (mem_wait),
    .timeout(timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT: state_nx = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    state_nx = S_DECODE;
        else if (timeout) state_nx = S_ERROR;
      end
      S_DECODE: begin
        if (is_halt)        state_nx = S_HALT;
        else if (!is_legal) state_nx = S_ERROR;
        else                state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (opcode == OP_LOAD || opcode == OP_STORE)
          state_nx = S_MEM;
        else if (opcode == OP_BRANCH)
          state_nx = S_FETCH;
        else
          state_nx = S_WB;
      end
      S_MEM: begin
        if (mem_ready)
          state_nx = (opcode == OP_STORE) ? S_FETCH : S_WB;
        else if (timeout)
          state_nx = S_ERROR;
      end
      S_WB:    state_nx = S_FETCH;
      S_HALT:  state_nx = S_HALT;
      S_ERROR: state_nx = S_ERROR;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_INC;
    reg_write   = 1'b0;
    wb_sel      = WB_ALU;
    alu_src_imm = 1'b0;
    retire      = 1'b0;
    halted      = 1'b0;
    error       = 1'b0;
    unique case (state)
      S_INIT, S_DECODE: ;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_INC;
        end
      end
      S_EXEC: begin
        alu_src_imm = opcode inside {OP_IALU, OP_LOAD, OP_STORE};
        if (opcode == OP_BRANCH) begin
          retire = 1'b1;
          if (taken) begin
            pc_write = 1'b1;
            pc_src   = func[3] ? PC_REG : PC_LABEL;
            if (func[2]) begin
              reg_write = 1'b1;
              wb_sel    = WB_LINK;
            end
          end
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opcode == OP_STORE);
        retire  = mem_ready && (opcode == OP_STORE);
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (opcode == OP_LOAD) ? WB_MEM : WB_ALU;
        retire    = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_ERROR: error  = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_kgp_control_fsm.sv
// Scoreboard bench for kgp_control_fsm: directed per-cycle
// output vectors queued by stimulus, checked by a monitor.
module tb_kgp_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = '0;
  logic [3:0] func = '0;
  logic       flag_z = 1'b0;
  logic       flag_c = 1'b0;
  logic       flag_s = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, mem_we, ir_write, pc_write;
  logic [1:0] pc_src, wb_sel;
  logic       reg_write, alu_src_imm, retire, halted, error;

  always #5 clk = ~clk;

  kgp_control_fsm #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .func       (func),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .flag_s     (flag_s),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .wb_sel     (wb_sel),
    .alu_src_imm(alu_src_imm),
    .retire     (retire),
    .halted     (halted),
    .error      (error)
  );

  // {req,we,ir,pcw,pc_src,rw,wb_sel,imm,ret,hlt,err}
  logic [12:0] act;
  assign act = {mem_req, mem_we, ir_write, pc_write, pc_src,
                reg_write, wb_sel, alu_src_imm, retire,
                halted, error};

  localparam logic [12:0] Z       = 13'b0_0_0_0_00_0_00_0_0_0_0;
  localparam logic [12:0] F_WAIT  = 13'b1_0_0_0_00_0_00_0_0_0_0;
  localparam logic [12:0] F_ACC   = 13'b1_0_1_1_00_0_00_0_0_0_0;
  localparam logic [12:0] EX_IMM  = 13'b0_0_0_0_00_0_00_1_0_0_0;
  localparam logic [12:0] WB_A    = 13'b0_0_0_0_00_1_00_0_1_0_0;
  localparam logic [12:0] WB_L    = 13'b0_0_0_0_00_1_01_0_1_0_0;
  localparam logic [12:0] MEM_LD  = 13'b1_0_0_0_00_0_00_0_0_0_0;
  localparam logic [12:0] MEM_STW = 13'b1_1_0_0_00_0_00_0_0_0_0;
  localparam logic [12:0] MEM_STR = 13'b1_1_0_0_00_0_00_0_1_0_0;
  localparam logic [12:0] BR_NT   = 13'b0_0_0_0_00_0_00_0_1_0_0;
  localparam logic [12:0] BR_T    = 13'b0_0_0_1_01_0_00_0_1_0_0;
  localparam logic [12:0] BR_JRL  = 13'b0_0_0_1_10_1_10_0_1_0_0;
  localparam logic [12:0] HLT     = 13'b0_0_0_0_00_0_00_0_0_1_0;
  localparam logic [12:0] ERR     = 13'b0_0_0_0_00_0_00_0_0_0_1;

  logic [12:0] exp_q[$];
  string       name_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [12:0] m_exp;
  string       m_name;

  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      m_exp  = exp_q.pop_front();
      m_name = name_q.pop_front();
      checks++;
      if (act !== m_exp) begin
        errors++;
        $display("FAIL %s: got %b want %b", m_name, act, m_exp);
      end
    end
  end

  task automatic step(input logic rdy, input logic [12:0] e,
                      input string n);
    mem_ready = rdy;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string n);
    rst = 1'b1;
    step(1'b1, Z, {n, "_rst"});
    rst = 1'b0;
    step(1'b1, Z, {n, "_init"});
  endtask

  task automatic front(input logic [2:0] op, input logic [3:0] f,
                       input string n);
    opcode = op;
    func   = f;
    step(1'b1, F_ACC, {n, "_fetch"});
    step(1'b1, Z, {n, "_decode"});
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    @(posedge clk);
    #1;
    step(1'b1, Z, "rst_c0");
    step(1'b1, Z, "rst_c1");
    step(1'b1, Z, "rst_c2");
    rst = 1'b0;
    step(1'b1, Z, "init");

    front(3'b000, 4'b0000, "ralu");
    step(1'b1, Z, "ralu_exec");
    step(1'b1, WB_A, "ralu_wb");

    front(3'b001, 4'b0000, "ialu");
    step(1'b1, EX_IMM, "ialu_exec");
    step(1'b1, WB_A, "ialu_wb");

    front(3'b010, 4'b0000, "load");
    step(1'b1, EX_IMM, "load_exec");
    for (int i = 0; i < 3; i++) step(1'b0, MEM_LD, "load_memwait");
    step(1'b1, MEM_LD, "load_memacc");
    step(1'b1, WB_L, "load_wb");

    front(3'b011, 4'b0000, "store");
    step(1'b1, EX_IMM, "store_exec");
    step(1'b1, MEM_STR, "store_mem0");
    front(3'b011, 4'b0000, "store1");
    step(1'b1, EX_IMM, "store1_exec");
    step(1'b0, MEM_STW, "store1_wait");
    step(1'b1, MEM_STR, "store1_acc");

    flag_z = 1'b0;
    front(3'b100, 4'b0001, "bz_nt");
    step(1'b1, BR_NT, "bz_nt_exec");
    flag_z = 1'b1;
    front(3'b100, 4'b0001, "bz_t");
    step(1'b1, BR_T, "bz_t_exec");
    front(3'b100, 4'b1100, "jrl");
    step(1'b1, BR_JRL, "jrl_exec");
    flag_c = 1'b0;
    front(3'b100, 4'b0010, "bc_nt");
    step(1'b1, BR_NT, "bc_nt_exec");
    flag_s = 1'b1;
    front(3'b100, 4'b0011, "bs_t");
    step(1'b1, BR_T, "bs_t_exec");

    opcode = 3'b000;
    func   = 4'b0000;
    for (int i = 0; i < 15; i++) step(1'b0, F_WAIT, "to_wait");
    step(1'b1, F_ACC, "to_last_accept");
    step(1'b1, Z, "to_decode");
    step(1'b1, Z, "to_exec");
    step(1'b1, WB_A, "to_wb");
    for (int i = 0; i < 16; i++) step(1'b0, F_WAIT, "to_stuck");
    step(1'b0, ERR, "to_error");
    step(1'b1, ERR, "error_sticky");
    do_reset("after_to");

    front(3'b101, 4'b0000, "ill101");
    step(1'b1, ERR, "ill101_err");
    do_reset("after_ill");
    front(3'b111, 4'b0000, "ill111");
    step(1'b1, ERR, "ill111_err");
    do_reset("after_ill2");

    front(3'b111, 4'b1111, "halt");
    step(1'b1, HLT, "halt_st");
    step(1'b0, HLT, "halt_sticky");
    do_reset("after_halt");

    front(3'b010, 4'b0000, "abort");
    step(1'b1, EX_IMM, "abort_exec");
    step(1'b0, MEM_LD, "abort_mem");
    rst = 1'b1;
    step(1'b0, Z, "abort_rst_async");
    rst = 1'b0;
    step(1'b1, Z, "abort_init");
    step(1'b1, F_ACC, "abort_refetch");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
